// File: rtl/inertial_integrator.sv
// inertial_integrator: sensor offset removal, gyro integration and
// complementary fusion producing pitch/pitch-rate for the balance PID.
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   vld          one-cycle strobe qualifying ptch_rt_raw / AZ
//   ptch_rt_raw  signed raw gyro pitch rate
//   AZ           signed raw Z acceleration
//   ptch         signed fused pitch (integrator bits 26:11)
//   ptch_rt      signed offset-corrected pitch rate
//   ptch_vld     one-cycle strobe, ptch/ptch_rt updated last edge
//   stale        sticky stream-timeout flag, cleared on entry to RUN

package inertial_pkg;
  typedef struct packed {
    logic signed [15:0] rt;
    logic signed [15:0] az;
  } s1_t;

  typedef enum logic {
    SETTLE = 1'b0,
    RUN    = 1'b1
  } st_t;
endpackage

module inertial_integrator
  import inertial_pkg::*;
#(
  parameter logic signed [15:0] PTCH_RT_OFFSET = 16'sh0050,
  parameter logic signed [15:0] AZ_OFFSET      = 16'sh00A0,
  parameter int                 SETTLE_SMPLS   = 8,
  parameter int                 TIMEOUT_CYC    = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vld,
  input  logic signed [15:0] ptch_rt_raw,
  input  logic signed [15:0] AZ,
  output logic signed [15:0] ptch,
  output logic signed [15:0] ptch_rt,
  output logic               ptch_vld,
  output logic               stale
);

  localparam int SW = $clog2(SETTLE_SMPLS + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic signed [28:0] P_MAX = 29'sd67108863;
  localparam logic signed [28:0] N_MIN = -29'sd67108864;

  function automatic logic signed [15:0] sat16(
    input logic signed [16:0] v
  );
    if (v > 17'sd32767) return 16'sh7FFF;
    else if (v < -17'sd32768) return 16'sh8000;
    else return v[15:0];
  endfunction

  s1_t                s1;
  logic               s1_vld;
  logic signed [16:0] rt_d;
  logic signed [16:0] az_d;

  st_t                state;
  st_t                state_nx;
  logic [SW-1:0]      scnt;
  logic [TW-1:0]      tcnt;

  logic signed [26:0] ptch_int;
  logic signed [15:0] s1_rt;
  logic signed [24:0] az_x;
  logic signed [24:0] prod;
  logic signed [15:0] ptch_acc;
  logic signed [28:0] sum;
  logic signed [26:0] sum_sat;

  logic               seed_upd;
  logic               run_upd;
  logic               settle_done;
  logic               tmo;

  // Stage 1: offset removal with saturation
  assign rt_d = 17'(ptch_rt_raw) - 17'(PTCH_RT_OFFSET);
  assign az_d = 17'(AZ) - 17'(AZ_OFFSET);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= '0;
      s1_vld <= 1'b0;
    end else begin
      s1_vld <= vld;
      if (vld) begin
        s1 <= '{rt: sat16(rt_d), az: sat16(az_d)};
      end
    end
  end

  // Stage 2 datapath: accel pitch ~ az * 327 / 8192
  assign s1_rt    = s1.rt;
  assign az_x     = 25'(s1.az);
  assign prod     = az_x * 25'sd327;
  assign ptch_acc = 16'(prod >>> 13);

  assign ptch = ptch_int[26:11];

  always_comb begin
    sum = 29'(ptch_int) - 29'(s1_rt);
    if (ptch_acc > ptch) sum = sum + 29'sd1024;
    else sum = sum - 29'sd1024;
  end

  always_comb begin
    if (sum > P_MAX) sum_sat = 27'sh3FFFFFF;
    else if (sum < N_MIN) sum_sat = 27'sh4000000;
    else sum_sat = sum[26:0];
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SETTLE;
    else state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    unique case (state)
      SETTLE: if (settle_done) state_nx = RUN;
      RUN:    if (tmo) state_nx = SETTLE;
      default: state_nx = SETTLE;
    endcase
  end

  // FSM: outputs / qualifiers
  always_comb begin
    seed_upd    = s1_vld && (state == SETTLE);
    run_upd     = s1_vld && (state == RUN);
    settle_done = seed_upd &&
                  (scnt == SW'(SETTLE_SMPLS - 1));
    // a vld on the would-be timeout cycle wins
    tmo         = (state == RUN) && !vld &&
                  (tcnt == TW'(TIMEOUT_CYC - 1));
  end

  // Counters and sticky stale flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt  <= '0;
      tcnt  <= '0;
      stale <= 1'b0;
    end else begin
      if (tmo) scnt <= '0;
      else if (settle_done) scnt <= '0;
      else if (seed_upd) scnt <= scnt + SW'(1);

      if (vld) tcnt <= '0;
      else if (tmo) tcnt <= '0;
      else if (state == RUN) tcnt <= tcnt + TW'(1);

      if (tmo) stale <= 1'b1;
      else if (settle_done) stale <= 1'b0;
    end
  end

  // Integrator and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptch_int <= '0;
      ptch_rt  <= '0;
      ptch_vld <= 1'b0;
    end else begin
      ptch_vld <= run_upd;
      if (s1_vld) ptch_rt <= s1_rt;
      if (seed_upd) ptch_int <= {ptch_acc, 11'b0};
      else if (run_upd) ptch_int <= sum_sat;
    end
  end

endmodule

// File: tb/tb_inertial_integrator.sv
// tb_inertial_integrator: directed stimulus with a queue scoreboard
// and an independent negedge monitor for inertial_integrator.

module tb_inertial_integrator;

  localparam logic [15:0] RT_OFF = 16'h0050;
  localparam logic [15:0] AZ_OFF = 16'h00A0;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               vld = 1'b0;
  logic [15:0]        raw = '0;
  logic [15:0]        az = '0;
  logic signed [15:0] ptch;
  logic signed [15:0] ptch_rt;
  logic               ptch_vld;
  logic               stale;

  inertial_integrator #(
    .PTCH_RT_OFFSET(16'sh0050),
    .AZ_OFFSET     (16'sh00A0),
    .SETTLE_SMPLS  (8),
    .TIMEOUT_CYC   (4096)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vld        (vld),
    .ptch_rt_raw(raw),
    .AZ         (az),
    .ptch       (ptch),
    .ptch_rt    (ptch_rt),
    .ptch_vld   (ptch_vld),
    .stale      (stale)
  );

  typedef struct {
    logic [15:0] p;
    logic [15:0] r;
    logic [26:0] i;
    int          cyc;
  } exp_t;

  exp_t   q[$];
  exp_t   me;
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     m_run = 0;
  int     m_cnt = 0;
  longint m_int = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every ptch_vld must match the oldest expectation
  always @(negedge clk) begin
    if (ptch_vld) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ptch_vld cyc=%0d ptch=%h want no strobe",
                 cyc, ptch);
      end else begin
        me = q.pop_front();
        if (ptch !== me.p || ptch_rt !== me.r ||
            dut.ptch_int !== me.i || cyc != me.cyc) begin
          errors++;
          $display("FAIL out got ptch=%h rt=%h int=%h cyc=%0d want ptch=%h rt=%h int=%h cyc=%0d",
                   ptch, ptch_rt, dut.ptch_int, cyc,
                   me.p, me.r, me.i, me.cyc);
        end
      end
    end
  end

  function automatic logic [15:0] bsat(input int v);
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return 16'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drain(input string nm);
    for (int n = 0; n < 20 && q.size() != 0; n++) tick();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s pending=%0d want 0", nm, q.size());
      q.delete();
    end
  endtask

  // One strobe; the model decides whether an output is due
  task automatic send(input logic [15:0] r_in,
                      input logic [15:0] a_in,
                      input bit ov = 1'b0,
                      input int hp = 0,
                      input int hr = 0,
                      input int hi = 0);
    logic [15:0] rc;
    logic [15:0] ac;
    int          acc;
    longint      p;
    exp_t        e;
    vld = 1'b1;
    raw = r_in;
    az  = a_in;
    rc  = bsat(int'($signed(r_in)) - int'($signed(RT_OFF)));
    ac  = bsat(int'($signed(a_in)) - int'($signed(AZ_OFF)));
    acc = (int'($signed(ac)) * 327) >>> 13;
    if (m_run == 0) begin
      m_int = longint'(acc) * 2048;
      m_cnt++;
      if (m_cnt == 8) begin
        m_run = 1;
        m_cnt = 0;
      end
    end else begin
      p = m_int >>> 11;
      m_int = m_int - longint'($signed(rc)) +
              ((longint'(acc) > p) ? 1024 : -1024);
      if (m_int > 67108863) m_int = 67108863;
      if (m_int < -67108864) m_int = -67108864;
      e.p   = 16'(m_int >>> 11);
      e.r   = rc;
      e.i   = 27'(m_int);
      e.cyc = cyc + 2;
      if (ov) begin
        e.p = 16'(hp);
        e.r = 16'(hr);
        e.i = 27'(hi);
      end
      q.push_back(e);
    end
    tick();
    vld = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_ptch", ptch, 16'sh0000);
    chk("rst_ptch_rt", ptch_rt, 16'sh0000);
    chk("rst_ptch_vld", ptch_vld, 1'b0);
    chk("rst_stale", stale, 1'b0);
    rst_n = 1'b1;
    tick();

    // Seed from accelerometer
    for (int k = 0; k < 8; k++) send(RT_OFF, AZ_OFF + 16'h2000);
    tick();
    chk("seed_ptch", ptch, 16'sh0147);
    chk("seed_stale", stale, 1'b0);
    send(RT_OFF, AZ_OFF + 16'h2000);
    drain("seed_run");

    // Asynchronous reset in the middle of traffic
    send(RT_OFF + 16'h0100, AZ_OFF);
    send(RT_OFF, AZ_OFF + 16'h0400);
    vld = 1'b1;
    raw = 16'h1234;
    az  = 16'h0300;
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    m_run = 0;
    m_cnt = 0;
    m_int = 0;
    chk("arst_ptch", ptch, 16'sh0000);
    chk("arst_ptch_rt", ptch_rt, 16'sh0000);
    chk("arst_ptch_vld", ptch_vld, 1'b0);
    chk("arst_stale", stale, 1'b0);
    vld = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) send(RT_OFF, AZ_OFF);
    tick();
    chk("reseed_ptch", ptch, 16'sh0000);

    // Integration and fusion, hand-computed
    send(RT_OFF + 16'h0800, AZ_OFF, 1'b1, -2, 2048, -3072);
    tick();
    send(RT_OFF + 16'h0800, AZ_OFF, 1'b1, -2, 2048, -4096);
    tick();
    send(RT_OFF + 16'h0800, AZ_OFF, 1'b1, -3, 2048, -5120);
    tick();
    send(RT_OFF + 16'h0800, AZ_OFF, 1'b1, -3, 2048, -6144);
    drain("integ");
    chk("integ_rt", ptch_rt, 16'sh0800);

    // Back-to-back strobes
    for (int k = 0; k < 5; k++) send(RT_OFF - 16'h0100, AZ_OFF + 16'h1000);
    drain("b2b");

    // Timeout after 4096 idle cycles
    send(RT_OFF, AZ_OFF);
    repeat (4095) tick();
    chk("tmo_early", stale, 1'b0);
    tick();
    chk("tmo_stale", stale, 1'b1);
    m_run = 0;
    m_cnt = 0;
    for (int k = 0; k < 8; k++) send(RT_OFF, AZ_OFF + 16'h2000);
    chk("tmo_hold", stale, 1'b1);
    tick();
    chk("tmo_clear", stale, 1'b0);
    send(RT_OFF, AZ_OFF + 16'h2000);
    drain("tmo_rerun");

    // vld exactly on the timeout cycle keeps RUN
    send(RT_OFF, AZ_OFF);
    repeat (4095) tick();
    send(RT_OFF, AZ_OFF);
    chk("tmo_edge_a", stale, 1'b0);
    repeat (4) tick();
    chk("tmo_edge_b", stale, 1'b0);
    drain("tmo_edge");

    // Saturation of rate and integrator
    send(16'h8000, AZ_OFF);
    tick();
    chk("sat_rt", ptch_rt, 16'sh8000);
    for (int k = 0; k < 2200; k++) send(16'h8000, AZ_OFF);
    drain("sat");
    chk("sat_ptch", ptch, 16'sh7FFF);
    chk("sat_int", dut.ptch_int, 27'sh3FFFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inertial_integrator.md
# inertial_integrator

Upstream stage of the balance PID. Consumes raw pitch-rate and Z-accel samples from the inertial sensor interface. Removes fixed sensor offsets and integrates pitch rate into a pitch angle. A complementary-filter term steers that angle toward an accelerometer-derived pitch. Outputs `ptch`, `ptch_rt` and a one-cycle `ptch_vld` that drive the PID's `ptch`, `ptch_rt` and `vld` inputs directly. A startup/recovery state machine holds `ptch_vld` low until the estimate has been seeded, and flags a stale sensor stream.

## Interface
- `PTCH_RT_OFFSET`, default 16'sh0050: gyro pitch-rate zero offset, subtracted from every raw sample.
- `AZ_OFFSET`, default 16'sh00A0: Z-accel zero offset, subtracted from every raw sample.
- `SETTLE_SMPLS`, default 8: samples spent seeding in SETTLE before RUN.
- `TIMEOUT_CYC`, default 4096: clocks without `vld` in RUN before the stream is declared stale.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `vld`  in  1  one-cycle strobe; `ptch_rt_raw` and `AZ` are valid this cycle.
- `ptch_rt_raw`  in  16  signed raw gyro pitch rate.
- `AZ`  in  16  signed raw Z acceleration.
- `ptch`  out  16  signed fused pitch estimate.
- `ptch_rt`  out  16  signed offset-corrected pitch rate.
- `ptch_vld`  out  1  one-cycle strobe; `ptch` and `ptch_rt` were updated on the previous edge.
- `stale`  out  1  sticky flag: sensor stream timed out; cleared on the next entry to RUN.

## Operation
- **Stage 1 (edge where `vld`=1):**
  - Capture `rt_comp = ptch_rt_raw - PTCH_RT_OFFSET`, saturated to 16-bit signed (0x7FFF/0x8000).
  - Capture `az_comp = AZ - AZ_OFFSET`, saturated the same way.
  - Set internal `s1_vld`=1 for exactly one cycle.
- **Stage 2 (edge where `s1_vld`=1):**
  - `prod = az_comp * 327`, 25-bit signed.
  - `ptch_acc = sign-extend(prod[24:13])` to 16 bits.
  - `ptch_rt <= rt_comp` in every state.
- **Integrator `ptch_int`:** 27-bit signed. `ptch = ptch_int[26:11]` (combinational from the register).
- **State SETTLE** (reset state):
  - Each stage-2 sample loads `ptch_int <= {ptch_acc, 11'b0}`.
  - A sample counter increments on each stage-2 sample.
  - When the count reaches `SETTLE_SMPLS`, go to RUN, clear the counter and clear `stale`.
  - `ptch_vld` stays 0 throughout SETTLE, including the sample that triggers the transition.
- **State RUN:**
  - Each stage-2 sample: `ptch_int <= sat27(ptch_int - sext27(rt_comp) + fusion)`.
  - `fusion` = +1024 if `ptch_acc > ptch` (signed, current `ptch`), else -1024.
  - `sat27` clamps to 27'sh3FFFFFF / 27'sh4000000.
  - `ptch_vld` pulses on the following cycle.
- **Timeout counter:**
  - Clears on every `vld`; otherwise increments while in RUN.
  - Reaching `TIMEOUT_CYC` sets `stale`=1, moves to SETTLE, and clears both counters. `ptch_int` holds until reseeded.
  - `vld` on the same cycle the counter would reach `TIMEOUT_CYC`: `vld` wins, no timeout.
- A `vld` arriving while `s1_vld` is high is legal; the pipeline accepts one sample per cycle.

## Timing
- **Reset (async):** `ptch`=0, `ptch_rt`=0, `ptch_vld`=0, `stale`=0, state=SETTLE, all counters and pipeline registers cleared. Reset mid-sample discards the sample.
- **Latency:** `vld` high in cycle N, then `ptch`/`ptch_rt` update at edge N+2, then `ptch_vld`=1 during cycle N+2 only.
- **Back-to-back `vld`:** one `ptch_vld` per `vld`, each exactly 2 cycles later.
- **SETTLE to RUN:** the first `ptch_vld` follows the first sample processed in RUN, i.e. sample `SETTLE_SMPLS`+1 after reset or timeout.

## Test plan
- **Reset:**
  - Assert `rst_n`=0 mid-operation with `vld` toggling.
  - Required: all outputs 0 asynchronously, and no `ptch_vld` for 8 samples after release.
- **Seed:**
  - `AZ = AZ_OFFSET + 0x2000`, rate at offset, 8 `vld` strobes.
  - Required: `ptch` = 327 (0x0147), `ptch_vld` never high, state RUN after strobe 8.
- **Integration and fusion:**
  - Seed with `AZ = AZ_OFFSET`, giving `ptch` = 0.
  - Then 4 strobes with `ptch_rt_raw = PTCH_RT_OFFSET + 0x0800`.
  - Required: `ptch_rt` = 0x0800.
  - Required `ptch_int` sequence -3072, -4096, -5120, -6144.
  - Required `ptch` sequence -2, -2, -3, -3.
  - Required: each `ptch_vld` exactly 2 cycles after its `vld`.
- **Saturation:**
  - `ptch_rt_raw` = 0x8000 gives `rt_comp` = 0x8000.
  - Sustained `ptch_rt_raw` = 0x8000 drives `ptch_int` to clamp at 0x3FFFFFF with no wrap, so `ptch` = 0x7FFF.
- **Timeout:**
  - In RUN, withhold `vld` for 4096 cycles.
  - Required: `stale`=1 and state SETTLE.
  - Then 8 strobes: `stale` returns to 0 and the next strobe yields `ptch_vld`.
  - Repeat with `vld` on cycle 4096 exactly: required no timeout.
- **Back-to-back:** 5 consecutive-cycle `vld` strobes in RUN produce 5 consecutive `ptch_vld` cycles, each carrying the correct incremental `ptch`.
